// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter: accepts one word per valid/ready handshake
// and shifts it out, optionally wrapped in an RS232 frame (start/parity/stop).
module piso_serializer #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int LSB_FIRST    = 1,
    parameter int FRAMED       = 1,
    parameter int STOP_BITS    = 1,
    parameter int PARITY       = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              serial_out,
    output logic              busy,
    output logic              done
);

    localparam int              DIVW      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [DIVW-1:0] DIV_LAST  = DIVW'(CLKS_PER_BIT - 1);
    localparam logic [4:0]      DATA_LAST = 5'(DATA_W - 1);
    localparam logic [4:0]      STOP_LAST = 5'(STOP_BITS - 1);
    localparam logic            IDLE_LVL  = (FRAMED != 0);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_PAR   = 3'd3;
    localparam logic [2:0] S_STOP  = 3'd4;

    // Absent frame sections are skipped by choosing the successor at elaboration.
    localparam logic [2:0] AFTER_PAR  = (FRAMED != 0) ? S_STOP : S_IDLE;
    localparam logic [2:0] AFTER_DATA = (PARITY != 0) ? S_PAR : AFTER_PAR;
    localparam logic [2:0] FIRST_ST   = (FRAMED != 0) ? S_START : S_DATA;

    logic [2:0]        state_q, state_d;
    logic [DIVW-1:0]   divCnt_q, divCnt_d;
    logic [4:0]        bitCnt_q, bitCnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              parity_q, parity_d;
    logic              line_q, line_d;
    logic              ready_q, ready_d;
    logic              done_q, done_d;
    logic              tick;

    assign tick = (divCnt_q == DIV_LAST);

    always_comb begin
        state_d  = state_q;
        divCnt_d = divCnt_q;
        bitCnt_d = bitCnt_q;
        shift_d  = shift_q;
        parity_d = parity_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid && ready_q) begin
                    shift_d  = in_data;
                    parity_d = (^in_data) ^ (PARITY == 2);
                    divCnt_d = '0;
                    bitCnt_d = '0;
                    state_d  = FIRST_ST;
                end
            end
            S_START: begin
                if (tick) state_d = S_DATA;
            end
            S_DATA: begin
                if (tick) begin
                    if (bitCnt_q == DATA_LAST) begin
                        bitCnt_d = '0;
                        state_d  = AFTER_DATA;
                    end else begin
                        bitCnt_d = bitCnt_q + 5'd1;
                        shift_d  = (LSB_FIRST != 0) ? (shift_q >> 1) : (shift_q << 1);
                    end
                end
            end
            S_PAR: begin
                if (tick) state_d = AFTER_PAR;
            end
            S_STOP: begin
                if (tick) begin
                    if (bitCnt_q == STOP_LAST) begin
                        bitCnt_d = '0;
                        state_d  = S_IDLE;
                    end else begin
                        bitCnt_d = bitCnt_q + 5'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (state_q != S_IDLE) begin
            divCnt_d = tick ? '0 : divCnt_q + DIVW'(1);
        end

        done_d  = (state_q != S_IDLE) && (state_d == S_IDLE);
        ready_d = (state_d == S_IDLE);

        // The line is computed from next-state values so every bit starts on its own edge.
        line_d = IDLE_LVL;
        case (state_d)
            S_START: line_d = 1'b0;
            S_DATA:  line_d = (LSB_FIRST != 0) ? shift_d[0] : shift_d[DATA_W-1];
            S_PAR:   line_d = parity_d;
            S_STOP:  line_d = 1'b1;
            default: line_d = IDLE_LVL;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            divCnt_q <= '0;
            bitCnt_q <= '0;
            shift_q  <= '0;
            parity_q <= 1'b0;
            line_q   <= IDLE_LVL;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            divCnt_q <= divCnt_d;
            bitCnt_q <= bitCnt_d;
            shift_q  <= shift_d;
            parity_q <= parity_d;
            line_q   <= line_d;
            ready_q  <= ready_d;
            done_q   <= done_d;
        end
    end

    assign serial_out = line_q;
    assign in_ready   = ready_q;
    assign busy       = ~ready_q;
    assign done       = done_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer: five parameter variants, expected line
// values queued from a reference frame model and popped once per clock.
module tb_piso_serializer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] dataIn [5];
    logic [4:0] validIn = '0;
    logic [4:0] lineOut, readyOut, busyOut, doneOut;

    int vectors = 0;
    int miscompares = 0;
    logic expLine [$];

    // Variants: 0 default, 1 raw MSB-first, 2 5-bit/2-stop, 3 even parity, 4 odd parity.
    int cfgW      [5] = '{8, 8, 5, 8, 8};
    int cfgC      [5] = '{16, 1, 3, 1, 1};
    int cfgLsb    [5] = '{1, 0, 1, 1, 1};
    int cfgFramed [5] = '{1, 0, 1, 1, 1};
    int cfgStop   [5] = '{1, 1, 2, 1, 1};
    int cfgPar    [5] = '{0, 0, 0, 1, 2};

    always #5 clk = ~clk;

    piso_serializer dutA (
        .clk(clk), .rst(rst), .in_data(dataIn[0]), .in_valid(validIn[0]),
        .in_ready(readyOut[0]), .serial_out(lineOut[0]), .busy(busyOut[0]), .done(doneOut[0]));

    piso_serializer #(.FRAMED(0), .LSB_FIRST(0), .CLKS_PER_BIT(1)) dutB (
        .clk(clk), .rst(rst), .in_data(dataIn[1]), .in_valid(validIn[1]),
        .in_ready(readyOut[1]), .serial_out(lineOut[1]), .busy(busyOut[1]), .done(doneOut[1]));

    piso_serializer #(.DATA_W(5), .STOP_BITS(2), .CLKS_PER_BIT(3)) dutC (
        .clk(clk), .rst(rst), .in_data(dataIn[2][4:0]), .in_valid(validIn[2]),
        .in_ready(readyOut[2]), .serial_out(lineOut[2]), .busy(busyOut[2]), .done(doneOut[2]));

    piso_serializer #(.PARITY(1), .CLKS_PER_BIT(1)) dutD (
        .clk(clk), .rst(rst), .in_data(dataIn[3]), .in_valid(validIn[3]),
        .in_ready(readyOut[3]), .serial_out(lineOut[3]), .busy(busyOut[3]), .done(doneOut[3]));

    piso_serializer #(.PARITY(2), .CLKS_PER_BIT(1)) dutE (
        .clk(clk), .rst(rst), .in_data(dataIn[4]), .in_valid(validIn[4]),
        .in_ready(readyOut[4]), .serial_out(lineOut[4]), .busy(busyOut[4]), .done(doneOut[4]));

    task automatic checkOutput(input string tag, input logic observed, input logic expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%b expected=%b at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic logic idleLevel(input int sel);
        return (cfgFramed[sel] != 0);
    endfunction

    // Reference frame builder: each bit repeated once per clock it is held.
    function automatic void pushFrame(input int sel, input logic [7:0] word);
        logic bits [$];
        logic p;
        p = 1'b0;
        if (cfgFramed[sel] != 0) bits.push_back(1'b0);
        for (int i = 0; i < cfgW[sel]; i++) begin
            bits.push_back(word[(cfgLsb[sel] != 0) ? i : cfgW[sel] - 1 - i]);
            p = p ^ word[i];
        end
        if (cfgPar[sel] == 1) bits.push_back(p);
        if (cfgPar[sel] == 2) bits.push_back(~p);
        if (cfgFramed[sel] != 0)
            for (int s = 0; s < cfgStop[sel]; s++) bits.push_back(1'b1);
        foreach (bits[b])
            for (int c = 0; c < cfgC[sel]; c++) expLine.push_back(bits[b]);
    endfunction

    // Drives one word, checks every cycle of its frame and the completion cycle.
    task automatic applyStimulus(input int sel, input logic [7:0] word, input int changeAt,
                                 input logic [7:0] newWord, input bit holdValid);
        int k;
        dataIn[sel]  = word;
        validIn[sel] = 1'b1;
        @(posedge clk);
        #1;
        if (!holdValid) validIn[sel] = 1'b0;
        pushFrame(sel, word);
        k = 0;
        while (expLine.size() > 0) begin
            @(negedge clk);
            if (k == changeAt) dataIn[sel] = newWord;
            checkOutput($sformatf("line[%0d] k=%0d", sel, k), lineOut[sel], expLine.pop_front());
            checkOutput($sformatf("ready[%0d]", sel), readyOut[sel], 1'b0);
            checkOutput($sformatf("busy[%0d]", sel), busyOut[sel], 1'b1);
            checkOutput($sformatf("doneLow[%0d]", sel), doneOut[sel], 1'b0);
            k++;
        end
        @(negedge clk);
        checkOutput($sformatf("endLine[%0d]", sel), lineOut[sel], idleLevel(sel));
        checkOutput($sformatf("endReady[%0d]", sel), readyOut[sel], 1'b1);
        checkOutput($sformatf("endDone[%0d]", sel), doneOut[sel], 1'b1);
        if (!holdValid) begin
            @(negedge clk);
            checkOutput($sformatf("donePulse[%0d]", sel), doneOut[sel], 1'b0);
            checkOutput($sformatf("idleLine[%0d]", sel), lineOut[sel], idleLevel(sel));
        end
    endtask

    initial begin
        for (int s = 0; s < 5; s++) dataIn[s] = 8'h00;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 5; s++) begin
            checkOutput($sformatf("rstLine[%0d]", s), lineOut[s], idleLevel(s));
            checkOutput($sformatf("rstReady[%0d]", s), readyOut[s], 1'b1);
            checkOutput($sformatf("rstBusy[%0d]", s), busyOut[s], 1'b0);
            checkOutput($sformatf("rstDone[%0d]", s), doneOut[s], 1'b0);
        end
        rst = 1'b1;
        @(negedge clk);

        $display("[TB] basic framed, raw and short-word frames");
        applyStimulus(0, 8'hA5, -1, 8'h00, 1'b0);
        applyStimulus(1, 8'hA5, -1, 8'h00, 1'b0);
        applyStimulus(2, 8'h13, -1, 8'h00, 1'b0);

        $display("[TB] parity frames");
        applyStimulus(3, 8'h07, -1, 8'h00, 1'b0);
        applyStimulus(3, 8'h03, -1, 8'h00, 1'b0);
        applyStimulus(4, 8'h07, -1, 8'h00, 1'b0);

        $display("[TB] back-to-back with data change mid-frame");
        applyStimulus(0, 8'h55, 40, 8'hFF, 1'b1);
        applyStimulus(0, 8'hFF, -1, 8'h00, 1'b0);

        $display("[TB] reset mid-frame");
        dataIn[0]  = 8'h96;
        validIn[0] = 1'b1;
        @(posedge clk);
        #1 validIn[0] = 1'b0;
        repeat (70) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        checkOutput("midRstLine", lineOut[0], 1'b1);
        checkOutput("midRstReady", readyOut[0], 1'b1);
        checkOutput("midRstBusy", busyOut[0], 1'b0);
        checkOutput("midRstDone", doneOut[0], 1'b0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            checkOutput("postRstDone", doneOut[0], 1'b0);
            checkOutput("postRstLine", lineOut[0], 1'b1);
        end
        applyStimulus(0, 8'h3C, -1, 8'h00, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
